// File: rtl/freq_pixel_pkg.sv
// Shared constants and types for the pixel frequency generator and its readout decoder.
// Both sides derive their count limits from these helpers so the mapping stays identical.
package freq_pixel_pkg;

  typedef enum logic {
    ARMING    = 1'b0,
    MEASURING = 1'b1
  } meas_state_t;

  function automatic int calc_max_count(input int clock_freq, input int low_freq);
    return clock_freq / (2 * low_freq);
  endfunction

  function automatic int calc_min_count(input int clock_freq, input int high_freq);
    return clock_freq / (2 * high_freq);
  endfunction

  function automatic int calc_step(input int max_count, input int min_count, input int input_bits);
    return (max_count - min_count) / ((1 << input_bits) - 1);
  endfunction

  function automatic int calc_counter_size(input int max_count);
    return $clog2(max_count + 1);
  endfunction

  function automatic int calc_timeout_cycles(input int max_count);
    return 2 * (max_count + 1);
  endfunction

endpackage

// File: rtl/repeated_sub_divider.sv
// Sequential restoring divider: one quotient bit per cycle, WIDTH_Q cycles per division.
// The caller must guarantee dividend < divisor * 2**WIDTH_Q (WIDTH_Q >= 2).
module repeated_sub_divider #(
  parameter int WIDTH_IN = 16,
  parameter int WIDTH_Q  = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                start,
  input  logic [WIDTH_IN-1:0] dividend,
  input  logic [WIDTH_IN-1:0] divisor,
  output logic                busy,
  output logic                done,
  output logic [WIDTH_Q-1:0]  quotient
);

  localparam int SH_W  = WIDTH_IN + WIDTH_Q - 1;
  localparam int BIT_W = $clog2(WIDTH_Q + 1);

  logic [WIDTH_IN-1:0] rem_q;
  logic [SH_W-1:0]     shifted_q;
  logic [BIT_W-1:0]    bits_left;
  logic                fits;

  // Trial subtraction of the divisor aligned to the current quotient bit.
  assign fits = (SH_W'(rem_q) >= shifted_q);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rem_q     <= '0;
      shifted_q <= '0;
      bits_left <= '0;
      quotient  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        rem_q     <= dividend;
        shifted_q <= SH_W'(divisor) << (WIDTH_Q - 1);
        bits_left <= BIT_W'(WIDTH_Q);
        quotient  <= '0;
        busy      <= 1'b1;
      end else if (busy) begin
        if (fits) rem_q <= rem_q - shifted_q[WIDTH_IN-1:0];
        quotient  <= {quotient[WIDTH_Q-2:0], fits};
        shifted_q <= shifted_q >> 1;
        bits_left <= bits_left - BIT_W'(1);
        if (bits_left == BIT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/freq_readout_decoder.sv
// Recovers the light value from a pixel square wave by timing its half-period and dividing.
// Optional FREQ_READOUT_OVERRUN_CNT_EN adds a saturating count of dropped measurements.
module freq_readout_decoder
  import freq_pixel_pkg::*;
#(
  parameter int CLOCK_FREQ  = 50_000_000,
  parameter int LOW_FREQ    = 1_000,
  parameter int HIGH_FREQ   = 20_000_000,
  parameter int INPUT_BITS  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  FREQ_IN,
  output logic [INPUT_BITS-1:0] VALUE_OUT,
  output logic                  VALUE_VALID,
  output logic                  TIMEOUT,
  output logic                  OVERRUN
`ifdef FREQ_READOUT_OVERRUN_CNT_EN
  ,
  output logic [7:0]            OVERRUN_COUNT
`endif
);

  localparam int MAX_COUNT      = calc_max_count(CLOCK_FREQ, LOW_FREQ);
  localparam int MIN_COUNT      = calc_min_count(CLOCK_FREQ, HIGH_FREQ);
  localparam int STEP           = calc_step(MAX_COUNT, MIN_COUNT, INPUT_BITS);
  localparam int TIMEOUT_CYCLES = calc_timeout_cycles(MAX_COUNT);
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SAT_LIMIT      = STEP << INPUT_BITS;
  localparam int DIV_W          = $clog2(SAT_LIMIT);
  localparam int D_W            = CNT_W + 2;

  localparam logic signed [D_W-1:0] MAX_S = D_W'(MAX_COUNT);
  localparam logic signed [D_W-1:0] SAT_S = D_W'(SAT_LIMIT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   freq_prev;
  logic                   freq_edge;
  logic [CNT_W-1:0]       interval_cnt;
  logic                   timeout_hit;
  meas_state_t            state_q, state_d;
  logic                   start_div, drop_meas;
  logic signed [D_W-1:0]  diff;
  logic [DIV_W-1:0]       dividend;
  logic                   div_busy, div_done;
  logic [INPUT_BITS-1:0]  quotient;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync_q    <= '0;
      freq_prev <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], FREQ_IN};
      freq_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign freq_edge = sync_q[SYNC_STAGES-1] ^ freq_prev;

  // Threshold is detected one count early so TIMEOUT rises as the counter saturates, once only.
  assign timeout_hit = !freq_edge && (interval_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (!RST_N)                                        interval_cnt <= '0;
    else if (freq_edge)                                interval_cnt <= '0;
    else if (interval_cnt != CNT_W'(TIMEOUT_CYCLES))   interval_cnt <= interval_cnt + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= ARMING;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARMING:    if (freq_edge)   state_d = MEASURING;
      MEASURING: if (timeout_hit) state_d = ARMING;
      default:                    state_d = ARMING;
    endcase
  end

  always_comb begin
    start_div = 1'b0;
    drop_meas = 1'b0;
    if (state_q == MEASURING && freq_edge) begin
      if (div_busy) drop_meas = 1'b1;
      else          start_div = 1'b1;
    end
  end

  // d = MAX_COUNT + 1 - H with H = interval_cnt + 1; clamped so the divider never overflows.
  assign diff = MAX_S - $signed({2'b00, interval_cnt});

  always_comb begin
    if (diff[D_W-1] || diff == '0) dividend = '0;
    else if (diff >= SAT_S)        dividend = DIV_W'(SAT_LIMIT - 1);
    else                           dividend = diff[DIV_W-1:0];
  end

  repeated_sub_divider #(
    .WIDTH_IN (DIV_W),
    .WIDTH_Q  (INPUT_BITS)
  ) u_divider (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .start    (start_div),
    .dividend (dividend),
    .divisor  (DIV_W'(STEP)),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      VALUE_OUT   <= '0;
      VALUE_VALID <= 1'b0;
      TIMEOUT     <= 1'b0;
      OVERRUN     <= 1'b0;
    end else begin
      VALUE_VALID <= timeout_hit || div_done;
      OVERRUN     <= drop_meas;
      if (timeout_hit)   VALUE_OUT <= '0;
      else if (div_done) VALUE_OUT <= quotient;
      if (freq_edge)        TIMEOUT <= 1'b0;
      else if (timeout_hit) TIMEOUT <= 1'b1;
    end
  end

`ifdef FREQ_READOUT_OVERRUN_CNT_EN
  // Counts drops since the last VALUE_VALID; a drop in the VALUE_VALID cycle opens the new window.
  always_ff @(posedge CLK) begin
    if (!RST_N)                                 OVERRUN_COUNT <= '0;
    else if (VALUE_VALID)                       OVERRUN_COUNT <= {7'd0, drop_meas};
    else if (drop_meas && OVERRUN_COUNT != '1)  OVERRUN_COUNT <= OVERRUN_COUNT + 8'd1;
  end
`endif

endmodule

// File: tb/tb_freq_readout_decoder.sv
// Directed bench for freq_readout_decoder; also checks OVERRUN_COUNT when
// FREQ_READOUT_OVERRUN_CNT_EN is defined.
module tb_freq_readout_decoder;

  localparam int MAX_C  = 5000;
  localparam int STEP   = 19;
  localparam int TO_CYC = 10002;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       freq_in = 1'b0;
  logic [7:0] value_out;
  logic       value_valid, timeout, overrun;
`ifdef FREQ_READOUT_OVERRUN_CNT_EN
  logic [7:0] overrun_count;
`endif

  int cyc = 0;
  int vv_count = 0;
  int last_vv_cyc = -1;
  logic [7:0] last_vv_val = '0;
  int total = 0;
  int bad = 0;

  freq_readout_decoder #(
    .CLOCK_FREQ  (1_000_000),
    .LOW_FREQ    (100),
    .HIGH_FREQ   (250_000),
    .INPUT_BITS  (8),
    .SYNC_STAGES (2)
  ) dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .FREQ_IN     (freq_in),
    .VALUE_OUT   (value_out),
    .VALUE_VALID (value_valid),
    .TIMEOUT     (timeout),
    .OVERRUN     (overrun)
`ifdef FREQ_READOUT_OVERRUN_CNT_EN
    ,
    .OVERRUN_COUNT (overrun_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (value_valid === 1'b1) begin
      vv_count    = vv_count + 1;
      last_vv_cyc = cyc;
      last_vv_val = value_out;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic toggle_at(input int c);
    wait_cyc(c);
    freq_in = ~freq_in;
  endtask

  // Two edges h cycles apart; the second must yield expv exactly 12 cycles after its toggle
  // (2 synchroniser cycles plus INPUT_BITS+2 decode latency).
  task automatic measure(input int h, input logic [7:0] expv, input string tag);
    int k0;
    int k;
    k0 = cyc + 1;
    toggle_at(k0);
    k = k0 + h;
    toggle_at(k);
    wait_cyc(k + 13);
    check({tag, "_lat"}, last_vv_cyc - k, 12);
    check({tag, "_val"}, last_vv_val, expv);
  endtask

  // Steady stream of half-period h; only the window after warm-up is checked.
  task automatic stream(input int h, input int warm, input int win, input int exp_vv,
                        input int exp_ov, input string tag);
    int base;
    int nv;
    int no;
    base = cyc + 1;
    nv = 0;
    no = 0;
    for (int i = 0; i < warm + win; i++) begin
      wait_cyc(base + i);
      if (i % h == 0) freq_in = ~freq_in;
      @(negedge clk);
      if (i >= warm) begin
        if (value_valid === 1'b1) begin
          nv++;
          check({tag, "_val"}, value_out, 255);
`ifdef FREQ_READOUT_OVERRUN_CNT_EN
          check({tag, "_ovcnt"}, overrun_count, exp_ov / exp_vv);
`endif
        end
        if (overrun === 1'b1) no++;
      end
    end
    check({tag, "_nvalid"}, nv, exp_vv);
    check({tag, "_novr"}, no, exp_ov);
  endtask

  // Behavioural pixel generator: half-period for input v is MAX_COUNT - STEP*v + 1.
  task automatic gen(input int v, input int halves, input string tag);
    int h;
    int c;
    h = MAX_C - STEP * v + 1;
    c = cyc + 1;
    for (int i = 0; i < halves; i++) toggle_at(c + i * h);
    wait_cyc(c + halves * h - 1);
    check({tag, "_val"}, last_vv_val, v);
    check({tag, "_fresh"}, last_vv_cyc > c, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    int k0;
    int n0;
    int to_cyc;

    // Reset held while FREQ_IN toggles.
    wait_cyc(1);
    for (int i = 0; i < 5; i++) begin
      wait_cyc(cyc + 1);
      freq_in = ~freq_in;
      @(negedge clk);
      check("reset_outs", {value_out, value_valid, timeout, overrun}, 0);
    end
    freq_in = 1'b0;
    wait_cyc(cyc + 3);
    check("reset_novalid", vv_count, 0);
    rst_n = 1'b1;

    // First edge only arms the measurement.
    toggle_at(cyc + 2);
    wait_cyc(cyc + 20);
    check("arm_novalid", vv_count, 0);
    check("arm_timeout", timeout, 0);

    measure(5001, 8'd0,   "h5001");
    measure(3101, 8'd100, "h3101");
    measure(156,  8'd255, "h156");
    measure(10,   8'd255, "h10_sat");
    measure(6000, 8'd0,   "h6000_clamp");
    check("h6000_noX", $isunknown({value_out, value_valid, timeout, overrun}), 0);

    // Timeout after lock.
    k = cyc + 1;
    toggle_at(k);
    wait_cyc(k + 13);
    n0 = vv_count;
    to_cyc = -1;
    for (int i = 0; i < TO_CYC + 100; i++) begin
      @(negedge clk);
      if (timeout === 1'b1) begin
        to_cyc = cyc;
        break;
      end
    end
    check("timeout_seen", to_cyc >= 0, 1);
    check("timeout_time", to_cyc - k, TO_CYC + 3);
    wait_cyc(to_cyc + 20);
    check("timeout_single_valid", vv_count, n0 + 1);
    check("timeout_value", last_vv_val, 0);
    check("timeout_valid_time", last_vv_cyc, to_cyc);
    check("timeout_held", timeout, 1);

    // Recovery: first edge clears TIMEOUT and re-arms, second yields a result.
    k0 = cyc + 1;
    toggle_at(k0);
    wait_cyc(k0 + 5);
    check("recover_timeout_clr", timeout, 0);
    check("recover_novalid", vv_count, n0 + 1);
    k = k0 + 3101;
    toggle_at(k);
    wait_cyc(k + 13);
    check("recover_lat", last_vv_cyc - k, 12);
    check("recover_val", last_vv_val, 100);

    // High light: drops while busy; edge coinciding with completion starts a new division.
    stream(4, 24, 48, 4, 8, "h4_overrun");
    stream(9, 18, 36, 4, 0, "h9_coincide");

    // Loopback with a generator model: 0 -> 37 -> 200.
    gen(0,   3, "loop0");
    gen(37,  3, "loop37");
    gen(200, 3, "loop200");

    // Reset during a division aborts it silently.
    k0 = cyc + 1;
    toggle_at(k0);
    k = k0 + 100;
    wait_cyc(k);
    n0 = vv_count;
    freq_in = ~freq_in;
    wait_cyc(k + 5);
    rst_n = 1'b0;
    wait_cyc(k + 8);
    rst_n = 1'b1;
    wait_cyc(k + 30);
    check("rst_abort_novalid", vv_count, n0);
    check("rst_abort_value", value_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
